// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// id_stage_if -- decode-to-execute bus
//
// Carries one decoded operation from the decode stage (master) to execute
// (slave) over a valid/ready handshake.
//
//   ex_valid   master->slave  decoded op valid
//   ex_ready   slave->master  execute accepts the op
//   ex_cond    master->slave  condition field, instr[31:28]
//   ex_class   master->slave  0=DP, 1=LDST, 2=BRANCH, 3=UNDEF
//   ex_opcode  master->slave  DP: instr[24:21]; LDST: {P,U,B,L}; BRANCH: {3'b0,L}
//   ex_rd      master->slave  destination register (r14 for BL)
//   ex_we      master->slave  op writes ex_rd
//   ex_op_a    master->slave  operand A (Rn value)
//   ex_op_b    master->slave  operand B (Rm, or Rd for stores)
//   ex_imm     master->slave  instr[23:0]
//   ex_immf    master->slave  instr[25]
// ---------------------------------------------------------------------------
interface id_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_cond;
    logic [1:0]  ex_class;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_rd;
    logic        ex_we;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [23:0] ex_imm;
    logic        ex_immf;

    modport master (
        output ex_valid, ex_cond, ex_class, ex_opcode, ex_rd, ex_we,
               ex_op_a, ex_op_b, ex_imm, ex_immf,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_cond, ex_class, ex_opcode, ex_rd, ex_we,
               ex_op_a, ex_op_b, ex_imm, ex_immf,
        output ex_ready
    );
endinterface

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- decode / operand-fetch stage
//
// Decodes one 32-bit ARM-style instruction, drives the register-file read
// addresses, captures the operands one cycle later and hands a decoded op to
// execute. A 16-bit scoreboard blocks issue on RAW/WAW hazards against
// destinations that are still awaiting writeback.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   instr, instr_valid   instruction word from fetch and its valid
//   instr_ready          instruction accepted this cycle (combinational)
//   pc_in                address of instr, sampled at accept
//   rd_addr1/2           register-file read addresses (combinational)
//   rd_data1/2           register-file data, valid the cycle after address
//   wb_we, wb_wa, wb_wd  writeback strobe, address and data
//   ex                   decoded-op bus to execute (id_stage_if.master)
//   sb_busy              scoreboard, one busy bit per register
//   stall_cnt            saturating count of cycles stalled on hazards
//
// Build option
//   ID_WB_BYPASS_EN  when defined, an instruction waiting on a register that
//                    is being written back this cycle issues immediately and
//                    takes the value from wb_wd instead of the register file.
// ---------------------------------------------------------------------------
module id_stage #(
    parameter logic [31:0] PC_OFFSET = 32'd8,
    parameter int          STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        pc_in,
    output logic [3:0]         rd_addr1,
    output logic [3:0]         rd_addr2,
    input  logic [31:0]        rd_data1,
    input  logic [31:0]        rd_data2,
    input  logic               wb_we,
    input  logic [3:0]         wb_wa,
    input  logic [31:0]        wb_wd,
    id_stage_if.master         ex,
    output logic [15:0]        sb_busy,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] CLS_DP    = 2'd0;
    localparam logic [1:0] CLS_LDST  = 2'd1;
    localparam logic [1:0] CLS_BR    = 2'd2;
    localparam logic [1:0] CLS_UNDEF = 2'd3;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  cls;
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic        we;
        logic [23:0] imm;
        logic        immf;
    } dec_t;

    logic [1:0]  state;
    dec_t        dec;
    dec_t        dec_l;
    logic        use_a;
    logic        use_b;
    logic [3:0]  ra_l;
    logic [3:0]  rb_l;
    logic [31:0] pc_l;
    logic [15:0] wb_mask;
    logic [15:0] set_mask;
    logic [15:0] busy_eff;
    logic        hazard;
    logic [31:0] op_a;
    logic [31:0] op_b;

    // ---------------- decode (purely from the incoming instruction) --------
    assign rd_addr1 = instr[19:16];

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec.cond   = instr[31:28];
        dec.cls    = CLS_UNDEF;
        dec.opcode = 4'd0;
        dec.rd     = instr[15:12];
        dec.we     = 1'b0;
        dec.imm    = instr[23:0];
        dec.immf   = instr[25];
        use_a      = 1'b0;
        use_b      = 1'b0;
        rd_addr2   = instr[3:0];
        if (instr[27:25] == 3'b101) begin
            dec.cls    = CLS_BR;
            dec.opcode = {3'b000, instr[24]};
            dec.rd     = 4'd14;
            dec.we     = instr[24];
        end else if (instr[27:26] == 2'b00) begin
            dec.cls    = CLS_DP;
            dec.opcode = instr[24:21];
            // TST/TEQ/CMP/CMN only update flags
            dec.we     = (instr[24:23] != 2'b10);
            use_a      = 1'b1;
            use_b      = 1'b1;
        end else if (instr[27:26] == 2'b01) begin
            dec.cls    = CLS_LDST;
            dec.opcode = {instr[24], instr[23], instr[22], instr[20]};
            dec.we     = instr[20];
            use_a      = 1'b1;
            use_b      = !instr[20];
            // stores need the data register as operand B
            if (!instr[20]) rd_addr2 = instr[15:12];
        end
    end

    // ---------------- hazard detection -------------------------------------
    assign wb_mask  = wb_we ? (16'd1 << wb_wa) : 16'd0;

`ifdef ID_WB_BYPASS_EN
    assign busy_eff = sb_busy & ~wb_mask;
`else
    assign busy_eff = sb_busy;
`endif

    // A pending PC write blocks everything: nothing younger may issue on a
    // path that is about to be redirected.
    assign hazard = busy_eff[15]
                  | (use_a  && (rd_addr1 != 4'd15) && busy_eff[rd_addr1])
                  | (use_b  && (rd_addr2 != 4'd15) && busy_eff[rd_addr2])
                  | (dec.we && busy_eff[dec.rd]);

    assign instr_ready = (state == ST_IDLE) && instr_valid && !hazard;
    assign set_mask    = (instr_ready && dec.we) ? (16'd1 << dec.rd) : 16'd0;

    // ---------------- operand selection during READ ------------------------
`ifdef ID_WB_BYPASS_EN
    logic        byp_a;
    logic        byp_b;
    logic [31:0] byp_a_d;
    logic [31:0] byp_b_d;

    // The register file is written on the same edge it registers the read,
    // so a value arriving by writeback in the accept cycle is taken here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp_a   <= 1'b0;
            byp_b   <= 1'b0;
            byp_a_d <= '0;
            byp_b_d <= '0;
        end else if (instr_ready) begin
            byp_a   <= wb_we && (wb_wa == rd_addr1);
            byp_b   <= wb_we && (wb_wa == rd_addr2);
            byp_a_d <= wb_wd;
            byp_b_d <= wb_wd;
        end
    end
`else
    logic unused_wb_wd;
    assign unused_wb_wd = ^wb_wd;
`endif

    always_comb begin
        op_a = rd_data1;
        op_b = rd_data2;
`ifdef ID_WB_BYPASS_EN
        if (byp_a) op_a = byp_a_d;
        if (byp_b) op_b = byp_b_d;
`endif
        // r15 never comes from the register file
        if (ra_l == 4'd15) op_a = pc_l + PC_OFFSET;
        if (rb_l == 4'd15) op_b = pc_l + PC_OFFSET;
    end

    // ---------------- state, scoreboard, execute bus -----------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sb_busy      <= '0;
            stall_cnt    <= '0;
            dec_l        <= '0;
            ra_l         <= '0;
            rb_l         <= '0;
            pc_l         <= '0;
            ex.ex_valid  <= 1'b0;
            ex.ex_cond   <= '0;
            ex.ex_class  <= '0;
            ex.ex_opcode <= '0;
            ex.ex_rd     <= '0;
            ex.ex_we     <= 1'b0;
            ex.ex_op_a   <= '0;
            ex.ex_op_b   <= '0;
            ex.ex_imm    <= '0;
            ex.ex_immf   <= 1'b0;
        end else begin
            // set after clear: a same-cycle set of one bit wins
            sb_busy <= (sb_busy & ~wb_mask) | set_mask;

            if ((state == ST_IDLE) && instr_valid && hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_W'(1);

            case (state)
                ST_IDLE: begin
                    if (instr_ready) begin
                        dec_l <= dec;
                        ra_l  <= rd_addr1;
                        rb_l  <= rd_addr2;
                        pc_l  <= pc_in;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    ex.ex_valid  <= 1'b1;
                    ex.ex_cond   <= dec_l.cond;
                    ex.ex_class  <= dec_l.cls;
                    ex.ex_opcode <= dec_l.opcode;
                    ex.ex_rd     <= dec_l.rd;
                    ex.ex_we     <= dec_l.we;
                    ex.ex_op_a   <= op_a;
                    ex.ex_op_b   <= op_b;
                    ex.ex_imm    <= dec_l.imm;
                    ex.ex_immf   <= dec_l.immf;
                    state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (ex.ex_ready) begin
                        ex.ex_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage
//
// A small register file model answers the read ports one cycle late and
// takes writebacks. Each issued op pushes its expected decode onto a queue;
// a monitor pops and compares whenever execute takes an op. Directed checks
// cover reset, latency, hazard stalls, writeback, the r15 rules, back-pressure
// and mid-op reset. Build with +define+ID_WB_BYPASS_EN to exercise bypass.
// ---------------------------------------------------------------------------
module tb_id_stage;

`ifdef ID_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  cls;
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic        we;
        logic [23:0] imm;
        logic        immf;
        logic        chk_a;
        logic [31:0] a;
        logic        chk_b;
        logic [31:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_in;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wb_we;
    logic [3:0]  wb_wa;
    logic [31:0] wb_wd;
    logic [15:0] sb_busy;
    logic [15:0] stall_cnt;

    id_stage_if exif ();

    id_stage #(.PC_OFFSET(32'd8), .STALL_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_in       (pc_in),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .wb_we       (wb_we),
        .wb_wa       (wb_wa),
        .wb_wd       (wb_wd),
        .ex          (exif.master),
        .sb_busy     (sb_busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // register file environment: 1-cycle registered read, write on wb_we
    logic [31:0] rf [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (wb_we) begin
            rf[wb_wa] <= wb_wd;
        end
        rd_data1 <= rf[rd_addr1];
        rd_data2 <= rf[rd_addr2];
    end

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_ops  = 0;
    exp_t q[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] ins, input logic [1:0] cls,
                                input logic [3:0] opc, input logic [3:0] rd,
                                input logic we, input logic ca, input logic [31:0] a,
                                input logic cb, input logic [31:0] b);
        exp_t e;
        e.cond  = ins[31:28];
        e.cls   = cls;
        e.opc   = opc;
        e.rd    = rd;
        e.we    = we;
        e.imm   = ins[23:0];
        e.immf  = ins[25];
        e.chk_a = ca;
        e.a     = a;
        e.chk_b = cb;
        e.b     = b;
        return e;
    endfunction

    // scoreboard monitor: one pop per op taken by execute
    always @(negedge clk) begin
        if (rst_n && exif.ex_valid && exif.ex_ready) begin
            check($sformatf("op%0d_expected", n_ops), 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                check($sformatf("op%0d_cond",   n_ops), exif.ex_cond,   mon_e.cond);
                check($sformatf("op%0d_class",  n_ops), exif.ex_class,  mon_e.cls);
                check($sformatf("op%0d_opcode", n_ops), exif.ex_opcode, mon_e.opc);
                check($sformatf("op%0d_rd",     n_ops), exif.ex_rd,     mon_e.rd);
                check($sformatf("op%0d_we",     n_ops), exif.ex_we,     mon_e.we);
                check($sformatf("op%0d_imm",    n_ops), exif.ex_imm,    mon_e.imm);
                check($sformatf("op%0d_immf",   n_ops), exif.ex_immf,   mon_e.immf);
                if (mon_e.chk_a) check($sformatf("op%0d_op_a", n_ops), exif.ex_op_a, mon_e.a);
                if (mon_e.chk_b) check($sformatf("op%0d_op_b", n_ops), exif.ex_op_b, mon_e.b);
            end
            n_ops++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for instr_ready, then take the accept edge
    task automatic accept(input string tag);
        int n = 0;
        #1;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_accept"}, instr_ready, 1);
        tick();
        instr_valid = 1'b0;
    endtask

    // wait (bounded) for ex_valid, then let execute take it
    task automatic wait_ex(input string tag);
        int n = 0;
        while (!exif.ex_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_ex_valid"}, exif.ex_valid, 1);
        tick();
    endtask

    task automatic issue(input string tag, input logic [31:0] ins,
                         input logic [31:0] pc, input exp_t e);
        instr       = ins;
        pc_in       = pc;
        instr_valid = 1'b1;
        q.push_back(e);
        accept(tag);
        wait_ex(tag);
    endtask

    task automatic wb(input logic [3:0] a, input logic [31:0] d);
        wb_we = 1'b1;
        wb_wa = a;
        wb_wd = d;
        tick();
        wb_we = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        instr         = 32'h0;
        instr_valid   = 1'b0;
        pc_in         = 32'h0;
        wb_we         = 1'b0;
        wb_wa         = 4'd0;
        wb_wd         = 32'h0;
        exif.ex_ready = 1'b1;
        tick();
        tick();

        // reset state
        check("rst_ex_valid",  exif.ex_valid, 0);
        check("rst_sb_busy",   sb_busy, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_ex_op_a",   exif.ex_op_a, 0);
        rst_n = 1'b1;
        tick();

        // ADD r1,r2,r3: latency and scoreboard set
        instr = 32'hE082_1003; pc_in = 32'h40; instr_valid = 1'b1;
        #1;
        check("add_ready",    instr_ready, 1);
        check("add_rd_addr1", rd_addr1, 2);
        check("add_rd_addr2", rd_addr2, 3);
        q.push_back(mk(32'hE082_1003, 2'd0, 4'b0100, 4'd1, 1'b1, 1'b1, rf[2], 1'b1, rf[3]));
        tick();
        instr_valid = 1'b0;
        check("add_ex_valid_n1", exif.ex_valid, 0);
        check("add_sb_busy",     sb_busy, 16'h0002);
        tick();
        check("add_ex_valid_n2", exif.ex_valid, 1);
        check("add_ex_rd",       exif.ex_rd, 1);
        tick();

        // ADD r6,r1,r2: stalls on busy r1 until writeback of r1
        instr = 32'hE081_6002; pc_in = 32'h44; instr_valid = 1'b1;
        #1;
        check("dep_stall_ready", instr_ready, 0);
        tick();
        check("dep_stall_cnt1", stall_cnt, 1);
        tick();
        check("dep_stall_cnt2", stall_cnt, 2);
        wb_we = 1'b1; wb_wa = 4'd1; wb_wd = 32'h1111_1111;
        #1;
        check("dep_ready_wb_cycle", instr_ready, 1'(BYP));
        if (!instr_ready) begin
            tick();
            wb_we = 1'b0;
            #1;
        end
        check("dep_ready", instr_ready, 1);
        check("dep_stall_final", stall_cnt, 32'(3 - BYP));
        q.push_back(mk(32'hE081_6002, 2'd0, 4'b0100, 4'd6, 1'b1, 1'b1, 32'h1111_1111, 1'b1, rf[2]));
        accept("dep");
        wb_we = 1'b0;
        check("dep_sb_busy", sb_busy, 16'h0040);
        wait_ex("dep");

        // STR r4,[r5]: Rd read on port 2, no write
        instr = 32'hE585_4000; pc_in = 32'h48; instr_valid = 1'b1;
        #1;
        check("str_rd_addr1", rd_addr1, 5);
        check("str_rd_addr2", rd_addr2, 4);
        q.push_back(mk(32'hE585_4000, 2'd1, 4'b1100, 4'd4, 1'b0, 1'b1, rf[5], 1'b1, rf[4]));
        accept("str");
        check("str_sb_busy", sb_busy, 16'h0040);
        wait_ex("str");

        // LDR r4,[r5] accepted while r4 (not busy) is written back: set wins
        instr = 32'hE595_4000; pc_in = 32'h4C; instr_valid = 1'b1;
        wb_we = 1'b1; wb_wa = 4'd4; wb_wd = 32'h4444_4444;
        q.push_back(mk(32'hE595_4000, 2'd1, 4'b1101, 4'd4, 1'b1, 1'b1, rf[5], 1'b0, 32'h0));
        accept("ldr");
        wb_we = 1'b0;
        check("ldr_sb_busy", sb_busy, 16'h0050);
        wait_ex("ldr");

        // writeback r4: still busy during the wb cycle, clear afterwards
        wb_we = 1'b1; wb_wa = 4'd4; wb_wd = 32'h4040_4040;
        #1;
        check("wb_busy_during", sb_busy[4], 1);
        tick();
        wb_we = 1'b0;
        check("wb_cleared", sb_busy, 16'h0040);
        wb(4'd6, 32'h6666_6666);
        check("wb_all_clear", sb_busy, 16'h0000);
        wb(4'd3, 32'h3333_3333);
        check("wb_idle_reg", sb_busy, 16'h0000);

        // BL: writes r14
        issue("bl", 32'hEB00_0010, 32'h50,
              mk(32'hEB00_0010, 2'd2, 4'b0001, 4'd14, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
        check("bl_sb_busy", sb_busy, 16'h4000);
        wb(4'd14, 32'h0000_0054);

        // MOV r0,pc: r15 operand is pc + 8
        issue("movpc", 32'hE1A0_000F, 32'h100,
              mk(32'hE1A0_000F, 2'd0, 4'b1101, 4'd0, 1'b1, 1'b1, rf[0], 1'b1, 32'h108));
        wb(4'd0, 32'h0000_0108);

        // MOV pc,r2 then CMP r1,r2: pending PC write stalls everything
        issue("mov2pc", 32'hE1A0_F002, 32'h104,
              mk(32'hE1A0_F002, 2'd0, 4'b1101, 4'd15, 1'b1, 1'b1, rf[0], 1'b1, rf[2]));
        check("pc_sb_busy", sb_busy, 16'h8000);
        instr = 32'hE151_0002; pc_in = 32'h108; instr_valid = 1'b1;
        #1;
        check("cmp_pc_stall", instr_ready, 0);
        tick();
        wb_we = 1'b1; wb_wa = 4'd15; wb_wd = 32'h0;
        #1;
        if (!instr_ready) begin
            tick();
            wb_we = 1'b0;
        end
        q.push_back(mk(32'hE151_0002, 2'd0, 4'b1010, 4'd0, 1'b0, 1'b1, rf[1], 1'b1, rf[2]));
        accept("cmp");
        wb_we = 1'b0;
        check("cmp_sb_busy",   sb_busy, 16'h0000);
        check("cmp_stall_cnt", stall_cnt, 32'(5 - 2 * BYP));
        wait_ex("cmp");

        // back-pressure: ex_* stable with ex_ready low, then reset mid-op
        exif.ex_ready = 1'b0;
        instr = 32'hE082_1003; pc_in = 32'h200; instr_valid = 1'b1;
        accept("bp");
        tick();
        instr = 32'hE151_0002; instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_valid_%0d", i), exif.ex_valid, 1);
            check($sformatf("bp_op_a_%0d", i),  exif.ex_op_a, rf[2]);
            check($sformatf("bp_rd_%0d", i),    exif.ex_rd, 1);
            check($sformatf("bp_ready_%0d", i), instr_ready, 0);
            tick();
        end
        check("bp_sb_busy", sb_busy, 16'h0002);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        tick();
        check("mid_rst_ex_valid", exif.ex_valid, 0);
        check("mid_rst_sb_busy",  sb_busy, 0);
        check("mid_rst_stall",    stall_cnt, 0);
        rst_n = 1'b1;
        exif.ex_ready = 1'b1;
        tick();

        // undefined encoding: class 3, no write
        issue("undef", 32'hEE00_0000, 32'h300,
              mk(32'hEE00_0000, 2'd3, 4'b0000, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        check("undef_sb_busy", sb_busy, 16'h0000);

        tick();
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
